// File: rtl/addsub_pipe.sv
// addsub_pipe: pipelined N-bit add/subtract, one carry-chained chunk resolved per stage, valid/ready handshakes and status flags
module addsub_pipe #(
  parameter int N      = 32,
  parameter int STAGES = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic         sub_i,
  input  logic         sign_i,
  input  logic [N-1:0] data0_i,
  input  logic [N-1:0] data1_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [N-1:0] data_o,
  output logic         carry_o,
  output logic         over_o,
  output logic         zero_o,
  output logic         neg_o
);
  localparam int C = N / STAGES;
  logic              en;
  logic [STAGES-1:0] v;
  assign out_valid_o = v[STAGES-1];
  assign en          = ~out_valid_o | out_ready_i;
  assign in_ready_o  = en;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) v <= '0;
    else if (flush_i) v <= '0;
    else if (en) v <= STAGES'({v, in_valid_i});
  // each stage carries only the operand chunks still to be consumed, shifted down so chunk k sits at [C-1:0]
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int I = N - k * C;
    logic [I-1:0]         a_i, b_i;
    logic [(k+1)*C-1:0]   s_nx;
    logic                 c_i, sub_x, sg_x;
    logic [C:0]           sum;
    if (k == 0) begin : g_head
      assign a_i   = data0_i;
      assign b_i   = sub_i ? ~data1_i : data1_i;
      assign c_i   = sub_i;
      assign sub_x = sub_i;
      assign sg_x  = sign_i;
      assign s_nx  = sum[C-1:0];
    end else begin : g_body
      assign a_i   = g_st[k-1].g_r.a_q;
      assign b_i   = g_st[k-1].g_r.b_q;
      assign c_i   = g_st[k-1].g_r.c_q;
      assign sub_x = g_st[k-1].g_r.sub_q;
      assign sg_x  = g_st[k-1].g_r.sg_q;
      assign s_nx  = {sum[C-1:0], g_st[k-1].g_r.s_q};
    end
    assign sum = {1'b0, a_i[C-1:0]} + {1'b0, b_i[C-1:0]} + {{C{1'b0}}, c_i};
    if (k < STAGES - 1) begin : g_r
      logic [I-C-1:0]     a_q, b_q;
      logic [(k+1)*C-1:0] s_q;
      logic               c_q, sub_q, sg_q;
      always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
          a_q   <= '0;
          b_q   <= '0;
          s_q   <= '0;
          c_q   <= 1'b0;
          sub_q <= 1'b0;
          sg_q  <= 1'b0;
        end else if (en) begin
          a_q   <= a_i[I-1:C];
          b_q   <= b_i[I-1:C];
          s_q   <= s_nx;
          c_q   <= sum[C];
          sub_q <= sub_x;
          sg_q  <= sg_x;
        end
    end else begin : g_o
      logic [N-1:0] d_q;
      logic         cy_q, ov_q, z_q, n_q;
      always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
          d_q  <= '0;
          cy_q <= 1'b0;
          ov_q <= 1'b0;
          z_q  <= 1'b0;
          n_q  <= 1'b0;
        end else if (en) begin
          d_q  <= s_nx;
          cy_q <= sum[C];
          ov_q <= sg_x ? (a_i[C-1] == b_i[C-1]) && (sum[C-1] != a_i[C-1]) : sum[C] ^ sub_x;
          z_q  <= s_nx == '0;
          n_q  <= sg_x & sum[C-1];
        end
    end
  end
  assign data_o  = g_st[STAGES-1].g_o.d_q;
  assign carry_o = g_st[STAGES-1].g_o.cy_q;
  assign over_o  = g_st[STAGES-1].g_o.ov_q;
  assign zero_o  = g_st[STAGES-1].g_o.z_q;
  assign neg_o   = g_st[STAGES-1].g_o.n_q;
endmodule

// File: tb/tb_addsub_pipe.sv
// tb_addsub_pipe: directed checks of the 8-bit/2-stage unit plus randomised width sweeps against an (N+1)-bit model
module tb_addsub_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, flush;
  int errors = 0, checks = 0;
  logic m_iv, m_ir, m_sub, m_sign, m_ov_, m_or, m_cy, m_ov, m_z, m_ng;
  logic [7:0] m_a, m_b, m_d;
  logic w32_iv, w32_ir, w32_sub, w32_sign, w32_vo, w32_cy, w32_ov, w32_z, w32_ng;
  logic [31:0] w32_a, w32_b, w32_d;
  logic w16_iv, w16_ir, w16_sub, w16_sign, w16_vo, w16_cy, w16_ov, w16_z, w16_ng;
  logic [15:0] w16_a, w16_b, w16_d;
  logic w64_iv, w64_ir, w64_sub, w64_sign, w64_vo, w64_cy, w64_ov, w64_z, w64_ng;
  logic [63:0] w64_a, w64_b, w64_d;
  logic w_or;
  logic [67:0] q32[$], q16[$], q64[$];
  logic [7:0] sa[4], sb[4], se[4];
  int got32 = 0, got16 = 0, got64 = 0;

  addsub_pipe #(.N(8), .STAGES(2)) u_m (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(m_iv), .in_ready_o(m_ir),
    .sub_i(m_sub), .sign_i(m_sign), .data0_i(m_a), .data1_i(m_b), .out_valid_o(m_ov_),
    .out_ready_i(m_or), .data_o(m_d), .carry_o(m_cy), .over_o(m_ov), .zero_o(m_z), .neg_o(m_ng));
  addsub_pipe #(.N(32), .STAGES(4)) u_w32 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(w32_iv), .in_ready_o(w32_ir),
    .sub_i(w32_sub), .sign_i(w32_sign), .data0_i(w32_a), .data1_i(w32_b), .out_valid_o(w32_vo),
    .out_ready_i(w_or), .data_o(w32_d), .carry_o(w32_cy), .over_o(w32_ov), .zero_o(w32_z), .neg_o(w32_ng));
  addsub_pipe #(.N(16), .STAGES(1)) u_w16 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(w16_iv), .in_ready_o(w16_ir),
    .sub_i(w16_sub), .sign_i(w16_sign), .data0_i(w16_a), .data1_i(w16_b), .out_valid_o(w16_vo),
    .out_ready_i(w_or), .data_o(w16_d), .carry_o(w16_cy), .over_o(w16_ov), .zero_o(w16_z), .neg_o(w16_ng));
  addsub_pipe #(.N(64), .STAGES(8)) u_w64 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(w64_iv), .in_ready_o(w64_ir),
    .sub_i(w64_sub), .sign_i(w64_sign), .data0_i(w64_a), .data1_i(w64_b), .out_valid_o(w64_vo),
    .out_ready_i(w_or), .data_o(w64_d), .carry_o(w64_cy), .over_o(w64_ov), .zero_o(w64_z), .neg_o(w64_ng));

  task automatic chk(input string tag, input logic [67:0] obs, input logic [67:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // exact unsigned and sign-extended arithmetic in 66 bits; flags derived from range, not from the carry chain
  function automatic logic [67:0] ref_model(input int n, input logic [63:0] a, input logic [63:0] b,
                                            input logic sub, input logic sign);
    logic [65:0] m, ua, ub, ur, sx, sy, sr;
    logic [63:0] d;
    logic cy, ov, z, ng;
    m  = (66'd1 << n) - 66'd1;
    ua = {2'b00, a} & m;
    ub = {2'b00, b} & m;
    ur = sub ? ua - ub : ua + ub;
    d  = ur[63:0] & m[63:0];
    cy = sub ? (ua >= ub) : ur[n];
    sx = ua | (ua[n-1] ? ~m : 66'd0);
    sy = ub | (ub[n-1] ? ~m : 66'd0);
    sr = sub ? sx - sy : sx + sy;
    ov = sign ? (sr[n] != sr[n-1]) : (sub ? (ua < ub) : ur[n]);
    z  = (d == 64'd0);
    ng = sign & d[n-1];
    return {d, cy, ov, z, ng};
  endfunction

  task automatic op(input string tag, input logic [7:0] a, input logic [7:0] b, input logic sub,
                    input logic sign, input logic [7:0] ed, input logic ecy, input logic eov,
                    input logic ez, input logic eng);
    @(negedge clk);
    m_iv = 1'b1; m_a = a; m_b = b; m_sub = sub; m_sign = sign;
    @(negedge clk);
    m_iv = 1'b0;
    chk({tag, "/latency"}, 68'(m_ov_), 68'd0);
    @(negedge clk);
    chk({tag, "/valid"}, 68'(m_ov_), 68'd1);
    chk({tag, "/result"}, 68'({m_d, m_cy, m_ov, m_z, m_ng}), 68'({ed, ecy, eov, ez, eng}));
  endtask

  initial begin
    logic [63:0] ra, rb;
    rst = 1'b1; flush = 1'b0; m_or = 1'b1; w_or = 1'b1;
    m_iv = 1'b0; m_sub = 1'b0; m_sign = 1'b0; m_a = '0; m_b = '0;
    w32_iv = 1'b0; w32_sub = 1'b0; w32_sign = 1'b0; w32_a = '0; w32_b = '0;
    w16_iv = 1'b0; w16_sub = 1'b0; w16_sign = 1'b0; w16_a = '0; w16_b = '0;
    w64_iv = 1'b0; w64_sub = 1'b0; w64_sign = 1'b0; w64_a = '0; w64_b = '0;
    sa = '{8'h01, 8'h10, 8'h40, 8'hF0};
    sb = '{8'h02, 8'h20, 8'h41, 8'h0F};
    se = '{8'h03, 8'h30, 8'h81, 8'hFF};
    @(negedge clk);
    chk("reset/valid", 68'(m_ov_), 68'd0);
    chk("reset/outputs", 68'({m_d, m_cy, m_ov, m_z, m_ng}), 68'd0);
    chk("reset/in_ready", 68'(m_ir), 68'd1);
    rst = 1'b0;
    op("s_add_ovf", 8'h7F, 8'h01, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1);
    op("u_sub_borrow", 8'h00, 8'h01, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0);
    op("u_sub_zero", 8'h05, 8'h05, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    op("s_sub_ovf", 8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b0);
    op("chunk_carry", 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0);
    op("u_add_wrap", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
    op("s_sub_neg", 8'hFF, 8'h01, 1'b1, 1'b1, 8'hFE, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c >= 2) begin
        chk("stream/valid", 68'(m_ov_), 68'd1);
        chk("stream/data", 68'(m_d), 68'(se[c-2]));
      end
      if (c < 4) begin
        m_iv = 1'b1; m_a = sa[c]; m_b = sb[c]; m_sub = 1'b0; m_sign = 1'b0;
      end else m_iv = 1'b0;
    end
    @(negedge clk);
    m_iv = 1'b1; m_a = 8'h12; m_b = 8'h34;
    @(negedge clk);
    m_a = 8'h22; m_b = 8'h11;
    @(negedge clk);
    chk("stall/first", 68'({m_ov_, m_d}), 68'({1'b1, 8'h46}));
    m_or = 1'b0; m_a = 8'h01; m_b = 8'h02;
    #1 chk("stall/in_ready", 68'(m_ir), 68'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("stall/hold", 68'({m_ov_, m_d, m_cy, m_ov, m_z, m_ng}), 68'({1'b1, 8'h46, 4'b0000}));
      chk("stall/in_ready", 68'(m_ir), 68'd0);
    end
    m_or = 1'b1;
    @(negedge clk);
    chk("release/second", 68'({m_ov_, m_d}), 68'({1'b1, 8'h33}));
    m_iv = 1'b0;
    @(negedge clk);
    chk("release/third", 68'({m_ov_, m_d}), 68'({1'b1, 8'h03}));
    @(negedge clk);
    chk("release/drained", 68'(m_ov_), 68'd0);
    m_iv = 1'b1; m_a = 8'h11; m_b = 8'h11;
    @(negedge clk);
    m_iv = 1'b0; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush/none1", 68'(m_ov_), 68'd0);
    @(negedge clk);
    chk("flush/none2", 68'(m_ov_), 68'd0);
    m_iv = 1'b1; m_a = 8'h21; m_b = 8'h21;
    @(negedge clk);
    m_iv = 1'b0;
    @(negedge clk);
    chk("flush_stall/pending", 68'({m_ov_, m_d}), 68'({1'b1, 8'h42}));
    m_or = 1'b0; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; m_or = 1'b1;
    chk("flush_stall/cleared", 68'(m_ov_), 68'd0);
    m_iv = 1'b1; m_a = 8'h55; m_b = 8'h22;
    @(negedge clk);
    m_a = 8'h01; m_b = 8'h01;
    @(negedge clk);
    chk("pre_reset/result", 68'({m_ov_, m_d}), 68'({1'b1, 8'h77}));
    #2 rst = 1'b1; m_iv = 1'b0;
    #1 chk("async_reset/valid", 68'(m_ov_), 68'd0);
    chk("async_reset/outputs", 68'({m_d, m_cy, m_ov, m_z, m_ng}), 68'd0);
    chk("async_reset/in_ready", 68'(m_ir), 68'd1);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("post_reset/no_stale", 68'(m_ov_), 68'd0);
    end
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (w32_vo) begin
        chk("sweep32", {32'd0, w32_d, w32_cy, w32_ov, w32_z, w32_ng}, q32.pop_front());
        got32++;
      end
      if (w16_vo) begin
        chk("sweep16", {48'd0, w16_d, w16_cy, w16_ov, w16_z, w16_ng}, q16.pop_front());
        got16++;
      end
      if (w64_vo) begin
        chk("sweep64", {w64_d, w64_cy, w64_ov, w64_z, w64_ng}, q64.pop_front());
        got64++;
      end
      if (c < 20) begin
        ra = {$urandom, $urandom}; rb = {$urandom, $urandom};
        if (c == 0) begin ra = 64'hFFFF_FFFF_FFFF_FFFF; rb = 64'd1; end
        w32_iv = 1'b1; w32_a = ra[31:0]; w32_b = rb[31:0];
        w32_sub = 1'($urandom_range(0, 1)); w32_sign = 1'($urandom_range(0, 1));
        q32.push_back(ref_model(32, {32'd0, w32_a}, {32'd0, w32_b}, w32_sub, w32_sign));
        w16_iv = 1'b1; w16_a = ra[47:32]; w16_b = rb[47:32];
        w16_sub = 1'($urandom_range(0, 1)); w16_sign = 1'($urandom_range(0, 1));
        q16.push_back(ref_model(16, {48'd0, w16_a}, {48'd0, w16_b}, w16_sub, w16_sign));
        w64_iv = 1'b1; w64_a = ra; w64_b = rb;
        w64_sub = 1'($urandom_range(0, 1)); w64_sign = 1'($urandom_range(0, 1));
        q64.push_back(ref_model(64, w64_a, w64_b, w64_sub, w64_sign));
      end else begin
        w32_iv = 1'b0; w16_iv = 1'b0; w64_iv = 1'b0;
      end
    end
    chk("sweep32/count", 68'(got32), 68'd20);
    chk("sweep16/count", 68'(got16), 68'd20);
    chk("sweep64/count", 68'(got64), 68'd20);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
